// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types, constants and byte-merge helper for the APB register bank
package apb_pkg;

    typedef enum logic [0:0] {IDLE, ACCESS} apb_state_e;

    localparam int WAIT_CNT_W = 4;

    // Works on the widest bus; narrower banks zero-extend inputs and truncate the result.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) begin
                res[k*8 +: 8] = new_v[k*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - byte-strobed register file with async read and read-only mirror of hw_in
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int                  NUM_REGS   = 16,
    parameter int                  DATA_WIDTH = 32,
    parameter int                  IDX_W      = 4,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           we_i,
    input  logic [IDX_W-1:0]               waddr_i,
    input  logic [DATA_WIDTH-1:0]          wdata_i,
    input  logic [DATA_WIDTH/8-1:0]        wstrb_i,
    input  logic [IDX_W-1:0]               raddr_i,
    output logic [DATA_WIDTH-1:0]          rdata_o,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in_i,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out_o
);

    logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] merged;

    always_comb begin
        merged = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (waddr_i == IDX_W'(i)) begin
                merged = DATA_WIDTH'(byte_merge(32'(mem_q[i]), 32'(wdata_i), 4'(wstrb_i)));
            end
        end
    end

    // Read-only entries are never written, so their storage stays at its reset value of 0.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rst_i) begin
                mem_q[i] <= '0;
            end else if (we_i && !RO_MASK[i] && waddr_i == IDX_W'(i)) begin
                mem_q[i] <= merged;
            end
        end
    end

    always_comb begin
        reg_out_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_out_o[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? hw_in_i[i*DATA_WIDTH +: DATA_WIDTH]
                                                               : mem_q[i];
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (raddr_i == IDX_W'(i)) begin
                rdata_o = reg_out_o[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/apb_slave_regbank.sv
// rtl/apb_slave_regbank.sv - APB4 slave register bank with wait states, byte strobes and error response
module apb_slave_regbank
    import apb_pkg::*;
#(
    parameter int                  ADDR_WIDTH  = 8,
    parameter int                  DATA_WIDTH  = 32,
    parameter int                  NUM_REGS    = 16,
    parameter int                  WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
    input  logic                           Pclk,
    input  logic                           Prst,
    input  logic                           PSELx,
    input  logic                           PENABLE,
    input  logic                           PWRITE,
    input  logic [ADDR_WIDTH-1:0]          PADDR,
    input  logic [DATA_WIDTH-1:0]          PWDATA,
    input  logic [DATA_WIDTH/8-1:0]        PSTRB,
    output logic [DATA_WIDTH-1:0]          PRDATA,
    output logic                           PREADY,
    output logic                           PSLVERR,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);

    apb_state_e            state_q;
    logic [WAIT_CNT_W-1:0] cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [BYTES-1:0]      strb_q;

    logic [ADDR_WIDTH-1:0] idx;
    logic                  in_range;
    logic                  misaligned;
    logic                  ro_hit;
    logic                  err;
    logic                  ready;
    logic                  commit;
    logic [DATA_WIDTH-1:0] rdata;

    always_comb begin
        idx        = addr_q >> OFF_W;
        in_range   = 32'(idx) < 32'(NUM_REGS);
        misaligned = |(addr_q & ALIGN_MASK);
        ro_hit     = in_range && RO_MASK[idx[IDX_W-1:0]];
        err        = !in_range || misaligned || (write_q && ro_hit);
        ready      = (state_q == ACCESS) && (cnt_q == '0);
        commit     = ready && PSELx && PENABLE && write_q && !err;
        PREADY     = ready;
        PSLVERR    = ready && err;
        PRDATA     = (ready && !write_q && !err) ? rdata : '0;
    end

    // Completion always returns to IDLE; a setup in the next cycle re-enters ACCESS from there.
    always_ff @(posedge Pclk) begin
        if (Prst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (PSELx && !PENABLE) begin
                        state_q <= ACCESS;
                        cnt_q   <= WAIT_CNT_W'(WAIT_STATES);
                        addr_q  <= PADDR;
                        write_q <= PWRITE;
                        wdata_q <= PWDATA;
                        strb_q  <= PSTRB;
                    end
                end
                ACCESS: begin
                    if (!PSELx) begin
                        state_q <= IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - WAIT_CNT_W'(1);
                    end else if (PENABLE) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    apb_slave_regfile #(
        .NUM_REGS   (NUM_REGS),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W),
        .RO_MASK    (RO_MASK)
    ) u_regfile (
        .clk_i     (Pclk),
        .rst_i     (Prst),
        .we_i      (commit),
        .waddr_i   (idx[IDX_W-1:0]),
        .wdata_i   (wdata_q),
        .wstrb_i   (strb_q),
        .raddr_i   (idx[IDX_W-1:0]),
        .rdata_o   (rdata),
        .hw_in_i   (hw_in),
        .reg_out_o (reg_out)
    );

endmodule

// File: tb/tb_apb_slave_regbank.sv
// tb/tb_apb_slave_regbank.sv - self-checking bench for apb_slave_regbank
module tb_apb_slave_regbank;

    localparam logic [15:0] RO = 16'h0084;

    logic         Pclk = 1'b0;
    logic         Prst, PSELx, PENABLE, PWRITE;
    logic [7:0]   PADDR;
    logic [31:0]  PWDATA;
    logic [3:0]   PSTRB;
    logic [511:0] hw_in;

    logic [31:0]  prdata0, prdata2, prdata3;
    logic         pready0, pready2, pready3;
    logic         pslverr0, pslverr2, pslverr3;
    logic [511:0] regout0, regout2, regout3;

    int           total = 0;
    int           bad   = 0;
    logic [31:0]  mdl [16];

    always #5 Pclk = ~Pclk;

    apb_slave_regbank #(.WAIT_STATES(0), .RO_MASK(RO)) u0 (
        .Pclk(Pclk), .Prst(Prst), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(prdata0), .PREADY(pready0),
        .PSLVERR(pslverr0), .hw_in(hw_in), .reg_out(regout0));

    apb_slave_regbank #(.WAIT_STATES(2), .RO_MASK(RO)) u2 (
        .Pclk(Pclk), .Prst(Prst), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(prdata2), .PREADY(pready2),
        .PSLVERR(pslverr2), .hw_in(hw_in), .reg_out(regout2));

    apb_slave_regbank #(.WAIT_STATES(3), .RO_MASK(RO)) u3 (
        .Pclk(Pclk), .Prst(Prst), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(prdata3), .PREADY(pready3),
        .PSLVERR(pslverr3), .hw_in(hw_in), .reg_out(regout3));

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    localparam int NV = 19;
    vec_t tbl [NV];

    function automatic logic get_ready(input int d);
        case (d)
            0:       return pready0;
            2:       return pready2;
            default: return pready3;
        endcase
    endfunction

    function automatic logic get_err(input int d);
        case (d)
            0:       return pslverr0;
            2:       return pslverr2;
            default: return pslverr3;
        endcase
    endfunction

    function automatic logic [31:0] get_rdata(input int d);
        case (d)
            0:       return prdata0;
            2:       return prdata2;
            default: return prdata3;
        endcase
    endfunction

    function automatic logic [31:0] get_reg(input int d, input int i);
        case (d)
            0:       return regout0[i*32 +: 32];
            2:       return regout2[i*32 +: 32];
            default: return regout3[i*32 +: 32];
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_access(input logic wr, input logic [7:0] a, input logic [31:0] d,
                                input logic [3:0] s, output logic e, output logic [31:0] r);
        int idx;
        idx = int'(a) / 4;
        e = 1'b0;
        r = '0;
        if ((a % 4) != 0 || idx >= 16) begin
            e = 1'b1;
        end else if (wr && RO[idx]) begin
            e = 1'b1;
        end else if (wr) begin
            for (int k = 0; k < 4; k++) begin
                if (s[k]) mdl[idx][k*8 +: 8] = d[k*8 +: 8];
            end
        end else begin
            r = RO[idx] ? hw_in[idx*32 +: 32] : mdl[idx];
        end
    endtask

    task automatic apb_xfer(input int d, input logic wr, input logic [7:0] a, input logic [31:0] wd,
                            input logic [3:0] s, output logic [31:0] rd, output logic e,
                            output int waits);
        logic early_bad;
        early_bad = 1'b0;
        @(posedge Pclk); #1;
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd; PSTRB = s;
        @(posedge Pclk); #1;
        PENABLE = 1'b1;
        waits = 0;
        forever begin
            @(negedge Pclk);
            if (get_ready(d)) break;
            if (get_rdata(d) !== 32'd0 || get_err(d) !== 1'b0) early_bad = 1'b1;
            waits++;
            if (waits > 40) break;
        end
        rd = get_rdata(d);
        e  = get_err(d);
        check("outputs_zero_while_waiting", {31'd0, early_bad}, 32'd0);
        @(posedge Pclk); #1;
        PSELx = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic check_u0_regs(input string nm);
        for (int i = 0; i < 16; i++) begin
            check(nm, get_reg(0, i), RO[i] ? hw_in[i*32 +: 32] : mdl[i]);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, mr;
        logic        e, me, wr, seen;
        logic [7:0]  a;
        logic [31:0] wd;
        logic [3:0]  s;
        int          waits;

        tbl[0]  = '{1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 8'h04, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF};
        tbl[2]  = '{1'b1, 8'h10, 32'hAABBCCDD, 4'hF, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, 8'h10, 32'h11223344, 4'h5, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 8'h10, 32'h0,        4'h0, 1'b0, 32'hAA22CC44};
        tbl[5]  = '{1'b0, 8'h40, 32'h0,        4'h0, 1'b1, 32'h0};
        tbl[6]  = '{1'b1, 8'h05, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0};
        tbl[7]  = '{1'b0, 8'h04, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF};
        tbl[8]  = '{1'b1, 8'h08, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0};
        tbl[9]  = '{1'b0, 8'h08, 32'h0,        4'h0, 1'b0, 32'hC0DE0002};
        tbl[10] = '{1'b1, 8'h14, 32'h12345678, 4'h0, 1'b0, 32'h0};
        tbl[11] = '{1'b0, 8'h14, 32'h0,        4'h0, 1'b0, 32'h0};
        tbl[12] = '{1'b1, 8'h3C, 32'h89ABCDEF, 4'hF, 1'b0, 32'h0};
        tbl[13] = '{1'b0, 8'h3C, 32'h0,        4'h0, 1'b0, 32'h89ABCDEF};
        tbl[14] = '{1'b1, 8'h40, 32'h5A5A5A5A, 4'hF, 1'b1, 32'h0};
        tbl[15] = '{1'b0, 8'h3D, 32'h0,        4'h0, 1'b1, 32'h0};
        tbl[16] = '{1'b0, 8'h00, 32'h0,        4'h0, 1'b0, 32'h0};
        tbl[17] = '{1'b1, 8'h1C, 32'h11111111, 4'hF, 1'b1, 32'h0};
        tbl[18] = '{1'b0, 8'h1C, 32'h0,        4'h0, 1'b0, 32'hC0DE0007};

        for (int i = 0; i < 16; i++) begin
            hw_in[i*32 +: 32] = 32'hC0DE0000 | 32'(i);
            mdl[i] = '0;
        end
        Prst = 1'b1; PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; PSTRB = '0;
        repeat (3) @(posedge Pclk);
        #1 Prst = 1'b0;
        @(negedge Pclk);
        check("reset_pready", {31'd0, pready0}, 32'd0);
        check("reset_pslverr", {31'd0, pslverr0}, 32'd0);
        check("reset_prdata", prdata0, 32'd0);
        check_u0_regs("reset_reg_out");

        for (int v = 0; v < NV; v++) begin
            apb_xfer(0, tbl[v].wr, tbl[v].addr, tbl[v].wdata, tbl[v].strb, rd, e, waits);
            model_access(tbl[v].wr, tbl[v].addr, tbl[v].wdata, tbl[v].strb, me, mr);
            check($sformatf("vec%0d_err", v), {31'd0, e}, {31'd0, tbl[v].err});
            check($sformatf("vec%0d_waits", v), 32'(waits), 32'd0);
            if (!tbl[v].wr) check($sformatf("vec%0d_rdata", v), rd, tbl[v].rdata);
        end
        check("reg_out_reg1", regout0[63:32], 32'hDEADBEEF);

        // PENABLE high with no preceding setup phase must be ignored.
        @(posedge Pclk); #1;
        PSELx = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 32'hFFFFFFFF; PSTRB = 4'hF;
        seen = 1'b0;
        repeat (3) begin
            @(negedge Pclk);
            if (pready0) seen = 1'b1;
        end
        check("idle_penable_no_ready", {31'd0, seen}, 32'd0);
        @(posedge Pclk); #1;
        PSELx = 1'b0; PENABLE = 1'b0;
        @(negedge Pclk);
        check("idle_penable_no_write", regout0[31:0], 32'd0);

        for (int n = 0; n < 80; n++) begin
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) a = 8'($urandom_range(0, 255));
            else a = 8'($urandom_range(0, 15) * 4);
            wd = $urandom;
            s  = 4'($urandom_range(0, 15));
            apb_xfer(0, wr, a, wd, s, rd, e, waits);
            model_access(wr, a, wd, s, me, mr);
            check($sformatf("rand%0d_err@%h", n, a), {31'd0, e}, {31'd0, me});
            check($sformatf("rand%0d_waits", n), 32'(waits), 32'd0);
            if (!wr) check($sformatf("rand%0d_rdata@%h", n, a), rd, mr);
        end
        check_u0_regs("rand_reg_out");

        apb_xfer(3, 1'b0, 8'h08, 32'h0, 4'h0, rd, e, waits);
        check("ws3_read_waits", 32'(waits), 32'd3);
        check("ws3_read_rdata", rd, 32'hC0DE0002);
        check("ws3_read_err", {31'd0, e}, 32'd0);
        apb_xfer(3, 1'b0, 8'h40, 32'h0, 4'h0, rd, e, waits);
        check("ws3_oob_waits", 32'(waits), 32'd3);
        check("ws3_oob_err", {31'd0, e}, 32'd1);
        check("ws3_oob_rdata", rd, 32'd0);

        // Abort: deselect after one wait cycle.
        @(posedge Pclk); #1;
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h10; PWDATA = 32'h55AA55AA; PSTRB = 4'hF;
        @(posedge Pclk); #1;
        PENABLE = 1'b1;
        @(negedge Pclk);
        check("abort_pre_ready", {31'd0, pready3}, 32'd0);
        @(posedge Pclk); #1;
        PSELx = 1'b0; PENABLE = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge Pclk);
            if (pready3 || pslverr3) seen = 1'b1;
        end
        check("abort_no_ready", {31'd0, seen}, 32'd0);
        check("abort_no_write", get_reg(3, 4), 32'd0);
        apb_xfer(3, 1'b1, 8'h10, 32'h0BADF00D, 4'hF, rd, e, waits);
        check("post_abort_write_waits", 32'(waits), 32'd3);
        check("post_abort_write_err", {31'd0, e}, 32'd0);
        apb_xfer(3, 1'b0, 8'h10, 32'h0, 4'h0, rd, e, waits);
        check("post_abort_read", rd, 32'h0BADF00D);

        // Reset asserted in the completion cycle of a WAIT_STATES=2 write.
        @(posedge Pclk); #1;
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h0C; PWDATA = 32'h12345678; PSTRB = 4'hF;
        @(posedge Pclk); #1;
        PENABLE = 1'b1;
        waits = 0;
        forever begin
            @(negedge Pclk);
            if (pready2) break;
            waits++;
            if (waits > 40) break;
        end
        check("rst_pre_waits", 32'(waits), 32'd2);
        Prst = 1'b1;
        @(posedge Pclk); #1;
        Prst = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge Pclk);
            if (pready2) seen = 1'b1;
        end
        check("rst_no_ready", {31'd0, seen}, 32'd0);
        check("rst_no_write", get_reg(2, 3), 32'd0);
        check("rst_clears_ws2_reg4", get_reg(2, 4), 32'd0);
        @(posedge Pclk); #1;
        PSELx = 1'b0; PENABLE = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
